branch_cond_unit: RTL and testbench
===================================

// Module: branch_cond_unit
// PURPOSE
//  Consumer end of the comparator interface: latches the comparator's eq/lt/gt result into a flag register.
//  Resolves conditional-branch requests from the decoder against the latched flags.
//  Returns taken/not-taken and the next PC to the fetch stage through a valid/ready handshake.
// PARAMETERS
//  AW    8  program-counter / branch-target width
//  CC_W  3  condition-code width
// PORTS
//  clk          in   1     system clock; all state updates on rising edge
//  rst          in   1     synchronous, active-high reset
//  cmp_wr       in   1     comparator result valid this cycle; latch flags
//  cmp_eq       in   1     comparator equal flag
//  cmp_lt       in   1     comparator less-than flag
//  cmp_gt       in   1     comparator greater-than flag
//  br_valid     in   1     branch request valid
//  br_ready     out  1     unit can accept a request (high only in IDLE)
//  br_cond      in   CC_W  condition code, captured on accept
//  br_target    in   AW    taken target, captured on accept
//  br_fallthru  in   AW    not-taken PC (PC+len), captured on accept
//  flush        in   1     abandon pending branch
//  res_valid    out  1     one-cycle result strobe
//  res_taken    out  1     branch taken; qualified by res_valid
//  res_pc       out  AW    next PC; qualified by res_valid
//  flags        out  3     registered {gt,lt,eq}
//  flags_valid  out  1     a compare has been latched since reset
// BEHAVIOUR
//  Reset: state=IDLE; br_ready=1; res_valid=0; res_taken=0; res_pc=0; flags=0; flags_valid=0.
//  Flag register:
//   - cmp_wr=1: flags<={gt,lt,eq} and flags_valid<=1 on that edge, in every state.
//   - flags are sticky; resolving a branch does not consume them.
//   - Malformed input (more than one of eq/lt/gt set) is stored as-is. Conditions use the stored bits literally.
//  Handshake: a request is accepted on an edge with br_valid && br_ready. cond/target/fallthru are captured that edge.
//  Condition codes:
//   000 ALWAYS   001 EQ   010 NE(!eq)   011 LT   100 GE(gt|eq)
//   101 GT       110 LE(lt|eq)          111 NEVER
//  FSM:
//   IDLE: br_ready=1; accept -> EVAL.
//   EVAL:
//    - flags_valid=1, or ALWAYS/NEVER: compute the condition from the registered flags.
//      Register res_taken and res_pc=taken?target:fallthru; set res_valid<=1 -> DONE.
//    - flags_valid=0 and condition needs flags -> WAIT.
//   WAIT: cmp_wr=1 -> EVAL (flags written the same edge); else stay.
//   DONE: res_valid=1 for exactly this cycle; -> IDLE. res_taken and res_pc hold until the next result.
//  Latency:
//   - accept edge E0; result visible in the cycle after E1 (2 edges).
//   - next accept possible at E3. Each WAIT cycle adds one.
//  Simultaneous events:
//   - cmp_wr on the accept edge: the new flags are used. Evaluation reads the register a cycle later.
//   - cmp_wr during EVAL: the old registered flags decide. The new flags land for later branches.
//   - flush=1 in EVAL/WAIT/DONE: -> IDLE next edge, res_valid=0. Flush has priority over all transitions.
//   - flush never blocks a flag write.
//   - flush in IDLE: no effect; a same-cycle accept is suppressed.
//  Mid-operation rst: returns to reset state regardless of state. A pending branch is dropped with no strobe.
//  Widths: res_pc is AW bits and no arithmetic is done here. PC wrap is the fetch stage's concern.
// STRUCTURE
//  Shared package (cpu_pkg):
//   - CC_* condition-code localparams.
//   - FSM state encodings IDLE/EVAL/WAIT/DONE.
//   - flag bit indices FLG_EQ=0, FLG_LT=1, FLG_GT=2.
//  One combinational sub-module cond_eval (cond, flags -> taken).
//  FSM, flag register and output registers live in the top.
// TESTING
//  1 rst; cmp_wr eq=1; BEQ target=8'h40 fallthru=8'h12 -> res_valid 2 edges later, taken=1, pc=8'h40.
//  2 Compare -31 vs -30 (lt=1); BGE target=8'h80 fallthru=8'h05 -> taken=0, pc=8'h05.
//    Then BLT with the same operands -> taken=1, pc=8'h80.
//  3 After rst, BGT with no compare -> WAIT with br_ready=0 for 3 cycles.
//    cmp_wr gt=1 -> res_valid next+1 cycle, taken=1.
//  4 Accept BNE while cmp_wr eq=1 on the same edge (old flags lt=1) -> taken=0.
//    cmp_wr during EVAL does not change the result.
//  5 flush in WAIT and in DONE -> res_valid stays 0 (or drops), state IDLE, br_ready=1 next cycle.
//    rst mid-EVAL -> all outputs at reset values.
//  6 All 8 cond codes x flag sets {eq},{lt},{gt} -> res_taken matches the table.
//    ALWAYS/NEVER resolve with flags_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the branch-condition path: condition codes,
// controller state encoding and flag-bit positions.
package cpu_pkg;

    localparam int CC_W = 3;

    localparam logic [CC_W-1:0] CC_ALWAYS = 3'b000;
    localparam logic [CC_W-1:0] CC_EQ     = 3'b001;
    localparam logic [CC_W-1:0] CC_NE     = 3'b010;
    localparam logic [CC_W-1:0] CC_LT     = 3'b011;
    localparam logic [CC_W-1:0] CC_GE     = 3'b100;
    localparam logic [CC_W-1:0] CC_GT     = 3'b101;
    localparam logic [CC_W-1:0] CC_LE     = 3'b110;
    localparam logic [CC_W-1:0] CC_NEVER  = 3'b111;

    localparam int FLG_EQ = 0;
    localparam int FLG_LT = 1;
    localparam int FLG_GT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition resolver: maps a condition code and the stored
// {gt,lt,eq} flags to a taken decision. Flag bits are used literally.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [CC_W-1:0] cond,
    input  logic [2:0]      flags,
    output logic            taken,
    output logic            needs_flags
);

    logic eq;
    logic lt;
    logic gt;

    assign eq = flags[FLG_EQ];
    assign lt = flags[FLG_LT];
    assign gt = flags[FLG_GT];

    assign needs_flags = (cond != CC_ALWAYS) && (cond != CC_NEVER);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves taken unassigned (no latch).
        taken = 1'b0;
        case (cond)
            CC_ALWAYS: taken = 1'b1;
            CC_EQ:     taken = eq;
            CC_NE:     taken = !eq;
            CC_LT:     taken = lt;
            CC_GE:     taken = gt | eq;
            CC_GT:     taken = gt;
            CC_LE:     taken = lt | eq;
            CC_NEVER:  taken = 1'b0;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Latches comparator flags and resolves conditional-branch requests against
// them, returning taken / next-PC to fetch through a valid/ready handshake.
module branch_cond_unit
    import cpu_pkg::*;
#(
    parameter int AW   = 8,
    parameter int CC_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmp_wr,
    input  logic            cmp_eq,
    input  logic            cmp_lt,
    input  logic            cmp_gt,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [CC_W-1:0] br_cond,
    input  logic [AW-1:0]   br_target,
    input  logic [AW-1:0]   br_fallthru,
    input  logic            flush,
    output logic            res_valid,
    output logic            res_taken,
    output logic [AW-1:0]   res_pc,
    output logic [2:0]      flags,
    output logic            flags_valid
);

    state_t          state;
    state_t          state_nx;
    logic [CC_W-1:0] cond_q;
    logic [AW-1:0]   target_q;
    logic [AW-1:0]   fallthru_q;
    logic            accept;
    logic            resolve;
    logic            can_resolve;
    logic            eval_taken;
    logic            eval_needs_flags;

    // Flush in IDLE only suppresses the accept; it has no other effect there.
    assign accept      = br_valid && br_ready && !flush;
    assign can_resolve = flags_valid || !eval_needs_flags;

    cond_eval u_cond_eval (
        .cond        (cond_q),
        .flags       (flags),
        .taken       (eval_taken),
        .needs_flags (eval_needs_flags)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush && state != ST_IDLE) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_nx = ST_EVAL;
                ST_EVAL: state_nx = can_resolve ? ST_DONE : ST_WAIT;
                ST_WAIT: if (cmp_wr) state_nx = ST_EVAL;
                ST_DONE: state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        br_ready = (state == ST_IDLE);
        resolve  = (state == ST_EVAL) && can_resolve && !flush;
    end

    // Flags are sticky and written in every state, flush included.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags       <= 3'b000;
            flags_valid <= 1'b0;
        end else if (cmp_wr) begin
            flags       <= {cmp_gt, cmp_lt, cmp_eq};
            flags_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cond_q     <= '0;
            target_q   <= '0;
            fallthru_q <= '0;
        end else if (accept) begin
            cond_q     <= br_cond;
            target_q   <= br_target;
            fallthru_q <= br_fallthru;
        end
    end

    // res_taken / res_pc hold between strobes; only res_valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_taken <= 1'b0;
            res_pc    <= '0;
        end else begin
            res_valid <= resolve;
            if (resolve) begin
                res_taken <= eval_taken;
                res_pc    <= eval_taken ? target_q : fallthru_q;
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: expected results go into a scoreboard
// queue, and a monitor checks them whenever res_valid strobes.
module tb_branch_cond_unit;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmp_wr = 1'b0, cmp_eq = 1'b0, cmp_lt = 1'b0, cmp_gt = 1'b0;
    logic       br_valid = 1'b0;
    logic       br_ready;
    logic [2:0] br_cond = '0;
    logic [7:0] br_target = '0, br_fallthru = '0;
    logic       flush = 1'b0;
    logic       res_valid, res_taken;
    logic [7:0] res_pc;
    logic [2:0] flags;
    logic       flags_valid;

    typedef struct {
        logic       taken;
        logic [7:0] pc;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    branch_cond_unit #(.AW(8), .CC_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmp_wr(cmp_wr), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_gt(cmp_gt),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
        .br_target(br_target), .br_fallthru(br_fallthru), .flush(flush),
        .res_valid(res_valid), .res_taken(res_taken), .res_pc(res_pc),
        .flags(flags), .flags_valid(flags_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("res_taken", {31'd0, res_taken}, {31'd0, e.taken});
                    check("res_pc", {24'd0, res_pc}, {24'd0, e.pc});
                    check("res_latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_cmp(input logic [2:0] cv);
        cmp_wr = 1'b1;
        cmp_gt = cv[2];
        cmp_lt = cv[1];
        cmp_eq = cv[0];
    endtask

    task automatic do_cmp(input logic [2:0] cv);
        set_cmp(cv);
        step();
        cmp_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        br_valid = 1'b0;
        cmp_wr = 1'b0;
        flush = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_br_ready"}, {31'd0, br_ready}, 32'd1);
        check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_res_taken"}, {31'd0, res_taken}, 32'd0);
        check({tag, "_res_pc"}, {24'd0, res_pc}, 32'd0);
        check({tag, "_flags"}, {29'd0, flags}, 32'd0);
        check({tag, "_flags_valid"}, {31'd0, flags_valid}, 32'd0);
    endtask

    // cmp_mode: 0 none, 1 compare on the accept edge, 2 compare during EVAL.
    task automatic branch(input logic [2:0] cc, input logic [7:0] tgt, input logic [7:0] ft,
                          input logic exp_taken, input int cmp_mode, input logic [2:0] cv);
        exp_t e;
        check("ready_idle", {31'd0, br_ready}, 32'd1);
        e.taken = exp_taken;
        e.pc    = exp_taken ? tgt : ft;
        e.cyc   = cyc + 2;
        sb.push_back(e);
        br_valid = 1'b1;
        br_cond = cc;
        br_target = tgt;
        br_fallthru = ft;
        if (cmp_mode == 1) set_cmp(cv);
        step();
        br_valid = 1'b0;
        cmp_wr = 1'b0;
        check("busy_eval", {31'd0, br_ready}, 32'd0);
        if (cmp_mode == 2) set_cmp(cv);
        step();
        cmp_wr = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] mask_eq;
        logic [7:0] mask_lt;
        logic [7:0] mask_gt;
        exp_t       e;

        // 1: reset state, then BEQ with eq latched.
        step();
        do_reset();
        check_reset("reset");
        do_cmp(3'b001);
        check("flags_eq", {29'd0, flags}, 32'h1);
        check("flags_valid_set", {31'd0, flags_valid}, 32'd1);
        branch(CC_EQ, 8'h40, 8'h12, 1'b1, 0, 3'b000);

        // 2: -31 vs -30 gives lt; BGE not taken, BLT taken.
        do_cmp(3'b010);
        branch(CC_GE, 8'h80, 8'h05, 1'b0, 0, 3'b000);
        branch(CC_LT, 8'h80, 8'h05, 1'b1, 0, 3'b000);

        // 3: BGT with no compare parks in WAIT until cmp_wr.
        do_reset();
        br_valid = 1'b1;
        br_cond = CC_GT;
        br_target = 8'h33;
        br_fallthru = 8'h44;
        step();
        br_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("wait_not_ready", {31'd0, br_ready}, 32'd0);
            step();
        end
        e.taken = 1'b1;
        e.pc    = 8'h33;
        e.cyc   = cyc + 2;
        sb.push_back(e);
        do_cmp(3'b100);
        step();
        step();

        // 4: compare on the accept edge is used; compare during EVAL is not.
        do_cmp(3'b010);
        branch(CC_NE, 8'h21, 8'h22, 1'b0, 1, 3'b001);
        branch(CC_EQ, 8'h31, 8'h32, 1'b1, 2, 3'b010);
        check("late_flags_land", {29'd0, flags}, 32'h2);

        // 5a: flush in WAIT, with a simultaneous flag write.
        do_reset();
        br_valid = 1'b1;
        br_cond = CC_LT;
        br_target = 8'h55;
        br_fallthru = 8'h66;
        step();
        br_valid = 1'b0;
        step();
        flush = 1'b1;
        set_cmp(3'b010);
        step();
        flush = 1'b0;
        cmp_wr = 1'b0;
        check("flush_wait_ready", {31'd0, br_ready}, 32'd1);
        check("flush_wait_nores", {31'd0, res_valid}, 32'd0);
        check("flush_keeps_flagwr", {29'd0, flags}, 32'h2);
        step();
        step();

        // 5b: flush in EVAL suppresses the strobe.
        br_valid = 1'b1;
        br_cond = CC_LT;
        step();
        br_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_eval_nores", {31'd0, res_valid}, 32'd0);
        check("flush_eval_ready", {31'd0, br_ready}, 32'd1);
        step();

        // 5c: flush in DONE drops the strobe after its one cycle.
        e.taken = 1'b0;
        e.pc    = 8'h78;
        e.cyc   = cyc + 2;
        sb.push_back(e);
        br_valid = 1'b1;
        br_cond = CC_GT;
        br_target = 8'h77;
        br_fallthru = 8'h78;
        step();
        br_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_done_drop", {31'd0, res_valid}, 32'd0);
        check("flush_done_ready", {31'd0, br_ready}, 32'd1);

        // 5d: flush in IDLE suppresses a same-cycle accept.
        flush = 1'b1;
        br_valid = 1'b1;
        step();
        flush = 1'b0;
        br_valid = 1'b0;
        check("flush_idle_noaccept", {31'd0, br_ready}, 32'd1);
        step();
        step();

        // 5e: reset in EVAL drops the pending branch.
        do_cmp(3'b001);
        branch(CC_EQ, 8'h40, 8'h12, 1'b1, 0, 3'b000);
        br_valid = 1'b1;
        br_cond = CC_EQ;
        step();
        br_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("mid_rst");
        step();
        step();

        // 6: full condition table against each single-flag set.
        mask_eq = 8'h53;
        mask_lt = 8'h4D;
        mask_gt = 8'h35;
        for (int f = 0; f < 3; f++) begin
            do_cmp(3'b001 << f);
            for (int c = 0; c < 8; c++) begin
                branch(c[2:0], 8'h90 + 8'(c), 8'h10 + 8'(c),
                       (f == 0) ? mask_eq[c] : (f == 1) ? mask_lt[c] : mask_gt[c], 0, 3'b000);
            end
        end

        // Malformed flags {lt,eq} are used literally.
        do_cmp(3'b011);
        branch(CC_NE, 8'hA1, 8'hA2, 1'b0, 0, 3'b000);
        branch(CC_LT, 8'hB1, 8'hB2, 1'b1, 0, 3'b000);

        // ALWAYS/NEVER resolve without any latched compare.
        do_reset();
        branch(CC_ALWAYS, 8'hC1, 8'hC2, 1'b1, 0, 3'b000);
        branch(CC_NEVER, 8'hD1, 8'hD2, 1'b0, 0, 3'b000);
        check("no_flags_yet", {31'd0, flags_valid}, 32'd0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        check("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
